control_unit: RTL and testbench

Main decoder for the 32-bit MIPS processor. Decodes the 6-bit instruction opcode into the datapath control signals: register-file write, ALU source and operation class, memory access, branch/jump, and the ori/lui immediate-handling selects. Outputs are registered. They feed the register file, the ALU control block, data memory and the PC-select logic.

---
 rtl/control_unit.sv | 59 +++++
 tb/tb_control_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: registered MIPS main opcode decoder producing datapath control signals
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       reg_dest,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_wrt,
  output logic       mem_read,
  output logic       mem_wrt,
  output logic       branch,
  output logic [1:0] alu_op,
  output logic       jump,
  output logic       jal,
  output logic       jr,
  output logic       bne,
  output logic       enable,
  output logic       ori,
  output logic       lui
);
  // control word layout:
  // {reg_dest, alu_src, mem_to_reg, reg_wrt, mem_read, mem_wrt, branch}_{alu_op}_{jump, jal, jr, bne, enable, ori, lui}
  localparam logic [15:0] CTRL_R   = 16'b1001000_10_0000100;
  localparam logic [15:0] CTRL_LW  = 16'b0111100_00_0000100;
  localparam logic [15:0] CTRL_SW  = 16'b0100010_00_0000100;
  localparam logic [15:0] CTRL_BEQ = 16'b0000001_01_0000100;
  localparam logic [15:0] CTRL_BNE = 16'b0000000_01_0001100;
  localparam logic [15:0] CTRL_J   = 16'b0000000_00_1000100;
  localparam logic [15:0] CTRL_JAL = 16'b0001000_00_1100100;
  localparam logic [15:0] CTRL_JR  = 16'b0000000_00_0010100;
  localparam logic [15:0] CTRL_ORI = 16'b0101000_11_0000110;
  localparam logic [15:0] CTRL_LUI = 16'b0101000_11_0000101;
  logic [15:0] ctrl_d, ctrl_q;
  // decode opcode; unrecognised opcodes yield an all-zero word so they never write state
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      6'b000000: ctrl_d = CTRL_R;
      6'b100011: ctrl_d = CTRL_LW;
      6'b101011: ctrl_d = CTRL_SW;
      6'b000100: ctrl_d = CTRL_BEQ;
      6'b000101: ctrl_d = CTRL_BNE;
      6'b000010: ctrl_d = CTRL_J;
      6'b000011: ctrl_d = CTRL_JAL;
      6'b001000: ctrl_d = CTRL_JR;
      6'b001101: ctrl_d = CTRL_ORI;
      6'b001111: ctrl_d = CTRL_LUI;
      default:   ctrl_d = '0;
    endcase
  end
  // register the control word; reset wins so an undriven opcode during reset cannot leak out
  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end
  assign {reg_dest, alu_src, mem_to_reg, reg_wrt, mem_read, mem_wrt, branch,
          alu_op, jump, jal, jr, bne, enable, ori, lui} = ctrl_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the registered opcode decoder
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       reg_dest, alu_src, mem_to_reg, reg_wrt, mem_read, mem_wrt, branch;
  logic [1:0] alu_op;
  logic       jump, jal, jr, bne, enable, ori, lui;
  int         checks = 0;
  int         fails = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .reg_dest(reg_dest), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_wrt(reg_wrt),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .branch(branch), .alu_op(alu_op),
    .jump(jump), .jal(jal), .jr(jr), .bne(bne), .enable(enable), .ori(ori), .lui(lui)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observed();
    return {reg_dest, alu_src, mem_to_reg, reg_wrt, mem_read, mem_wrt, branch,
            alu_op, jump, jal, jr, bne, enable, ori, lui};
  endfunction

  function automatic logic [15:0] model(input logic [5:0] op);
    logic rd, as, m2r, rw, mr, mw, br, jp, jl, jrr, bn, en, o, l;
    logic [1:0] ao;
    {rd, as, m2r, rw, mr, mw, br, jp, jl, jrr, bn, en, o, l} = '0;
    ao = 2'b00;
    en = 1'b1;
    if      (op == 6'b000000) begin rd = 1; rw = 1; ao = 2'b10; end
    else if (op == 6'b100011) begin as = 1; m2r = 1; rw = 1; mr = 1; end
    else if (op == 6'b101011) begin as = 1; mw = 1; end
    else if (op == 6'b000100) begin br = 1; ao = 2'b01; end
    else if (op == 6'b000101) begin bn = 1; ao = 2'b01; end
    else if (op == 6'b000010) jp = 1;
    else if (op == 6'b000011) begin jp = 1; jl = 1; rw = 1; end
    else if (op == 6'b001000) jrr = 1;
    else if (op == 6'b001101) begin as = 1; rw = 1; o = 1; ao = 2'b11; end
    else if (op == 6'b001111) begin as = 1; rw = 1; l = 1; ao = 2'b11; end
    else en = 0;
    return {rd, as, m2r, rw, mr, mw, br, ao, jp, jl, jrr, bn, en, o, l};
  endfunction

  task automatic pop_check();
    logic [15:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (observed() === e) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", t, observed(), e);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input string tag);
    reset = r;
    opcode = op;
    exp_q.push_back(r ? 16'h0000 : model(op));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic field(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b001111};
    reset = 1'b1;
    opcode = 6'b000000;
    step(1'b1, 6'b000000, "reset_0");
    step(1'b1, 6'b000000, "reset_1");
    step(1'b0, 6'b000000, "rtype_after_reset");
    field("rtype_reg_dest", reg_dest, 1'b1);
    field("rtype_alu_op1", alu_op[1], 1'b1);
    field("rtype_alu_op0", alu_op[0], 1'b0);
    foreach (ops[i]) step(1'b0, ops[i], $sformatf("stream_%b", ops[i]));
    step(1'b0, 6'b000100, "beq");
    field("beq_branch", branch, 1'b1);
    field("beq_bne", bne, 1'b0);
    field("beq_reg_wrt", reg_wrt, 1'b0);
    step(1'b0, 6'b000101, "bne");
    field("bne_branch", branch, 1'b0);
    field("bne_bne", bne, 1'b1);
    field("bne_alu_op0", alu_op[0], 1'b1);
    step(1'b0, 6'b000010, "j");
    field("j_jump", jump, 1'b1);
    field("j_jal", jal, 1'b0);
    field("j_reg_wrt", reg_wrt, 1'b0);
    step(1'b0, 6'b000011, "jal");
    field("jal_jump", jump, 1'b1);
    field("jal_jal", jal, 1'b1);
    field("jal_reg_wrt", reg_wrt, 1'b1);
    step(1'b0, 6'b111111, "unknown_111111");
    field("unknown_enable", enable, 1'b0);
    step(1'b0, 6'b001001, "unknown_001001");
    step(1'b0, 6'b000001, "unknown_000001");
    step(1'b0, 6'b100011, "lw_pre_reset");
    step(1'b1, 6'b100011, "lw_during_reset");
    step(1'b0, 6'b100011, "lw_after_reset");
    step(1'b1, 6'bxxxxxx, "x_opcode_in_reset");
    step(1'b0, 6'b001111, "lui_after_x");
    opcode = 6'b101011;
    exp_q.push_back(model(6'b001111));
    tag_q.push_back("hold_between_edges");
    #2;
    pop_check();
    step(1'b0, 6'b001101, "ori_after_change");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
